pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline-stage register with a valid/ready handshake, a two-entry skid buffer and a synchronous flush that inserts a configurable bubble. It is the generic successor of the fixed inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) in the RISC-V pipeline. A downstream stall propagates upstream one cycle late, through a registered `in_ready`, with no beat lost. The same block is instantiated at every stage boundary with different widths and bubble values.

## Interface
- `DATA_W`, 160: width of the datapath payload (operands, immediate, PCs, register addresses).
- `CTRL_W`, 16: width of the control-signal bundle.
- `CTRL_BUBBLE`, `'0`: control value presented when the stage is empty, flushed or in reset (e.g. write-enable bits forced to a no-op encoding).
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `flush`  in  1  synchronous kill of all held beats.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  stage can accept a beat; registered.
- `in_data`  in  DATA_W  upstream payload.
- `in_ctrl`  in  CTRL_W  upstream control bundle.
- `out_valid`  out  1  `out_data`/`out_ctrl` hold a live beat.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  DATA_W  registered payload.
- `out_ctrl`  out  CTRL_W  registered control.
- `count`  out  2  number of held beats, 0..2.

## Operation
- Handshakes:
  - Accept: `in_valid & in_ready` at an edge.
  - Deliver: `out_valid & out_ready` at an edge.
- Storage:
  - Main entry drives the outputs directly.
  - Skid entry holds the overflow beat.
- States:
  - EMPTY: `count` 0, `out_valid` 0, `in_ready` 1.
  - ONE: `count` 1, main full, `in_ready` 1.
  - TWO: `count` 2, main and skid full, `in_ready` 0.
- Transitions (no flush):
  - EMPTY + accept -> ONE. The beat is loaded into main.
  - ONE + accept + deliver -> ONE. Main is replaced by the new beat.
  - ONE + accept, no deliver -> TWO. The new beat goes to skid.
  - ONE + deliver, no accept -> EMPTY.
  - TWO + deliver -> ONE. Skid moves to main. No accept is possible in TWO.
  - All other combinations: hold.
- Flush (highest priority below reset):
  - Next state is EMPTY.
  - A beat accepted in the flush cycle is discarded.
  - A beat delivered in the flush cycle counts as delivered; the hazard unit owns flush timing.
- Bubble values: whenever main is empty (after reset, after flush, on a drain to EMPTY), `out_data` = 0 and `out_ctrl` = `CTRL_BUBBLE`.
- Ordering: beats leave in the same order they were accepted. No beat is duplicated; the only way a beat is dropped is a flush.
- Reset (asynchronous):
  - Outputs: `out_valid` 0, `out_data` 0, `out_ctrl` `CTRL_BUBBLE`, `count` 0, `in_ready` 1.
  - Skid contents are cleared.
  - Reset asserted mid-transfer abandons both entries.

## Timing
- Latency: an accepted beat appears on the outputs at the next edge (1 cycle) when the stage is EMPTY, or when it is ONE with a simultaneous deliver.
- Stall propagation:
  - `in_ready` falls one cycle after the first un-delivered accept into ONE.
  - The skid entry absorbs the beat upstream sends in that cycle.
- `in_ready` is a flop output. It has no combinational path from `out_ready` or `flush`.
- Throughput: 1 beat/cycle sustained while `out_ready` = 1.
- After flush, `out_valid` = 0 and `in_ready` = 1 from the next edge.

## Structure
- Shared package `pipe_pkg`:
  - State enum `pipe_state_t`: ST_EMPTY, ST_ONE, ST_TWO.
  - Per-boundary width constants (`IDEX_DATA_W`, `IDEX_CTRL_W`, ...).
  - Bubble constants: `IDEX_CTRL_BUBBLE` etc., including the register-write no-op encoding of the control bundle.
- No sub-module. The single module contains the state register, main and skid entries, and next-state logic.

## Test plan
- Reset, then hold `out_ready`=1 and drive 4 consecutive beats (data 1, 2, 3, 4) -> outputs show 1..4 on consecutive cycles, each 1 cycle after its accept; `count` stays 1; `in_ready` stays 1.
- Drive beat A, then at the next edge drive beat B while `out_ready`=0 -> `count`=2 and `in_ready`=0. Then raise `out_ready` for 2 cycles -> A then B delivered, `count` returns to 0.
- In TWO (beats A, B held), assert `flush` -> next edge: `out_valid`=0, `out_ctrl`=`CTRL_BUBBLE`, `out_data`=0, `count`=0, `in_ready`=1.
- In EMPTY, assert `flush` and `in_valid` with beat C in the same cycle -> C discarded, `out_valid` stays 0.
- In ONE, assert async `reset` between edges -> outputs take their reset values immediately, without waiting for `clk`.
- Randomised `in_valid`/`out_ready` for 10k cycles with a scoreboard -> in-order delivery and no loss or duplication; `count` never exceeds 2.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the pipeline-stage registers of the RISC-V core.
// Holds the occupancy state encoding used by every stage register, the
// payload/control widths of each stage boundary, the bit layout of the
// control bundles, and the bubble (no-op) control values each boundary
// presents when it holds no live instruction.
package pipe_pkg;

  // Occupancy of a stage register: nothing, main entry only, or main plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_t;

  // ---------------------------------------------------------------------------
  // Control-bundle field layout shared by the ID/EX, EX/MEM and MEM/WB bundles.
  // Later boundaries simply carry fewer of the upper fields, but bit positions
  // are kept identical so a bundle can be narrowed by truncation.
  // ---------------------------------------------------------------------------
  localparam int CTRL_REG_WRITE_BIT = 0;
  localparam int CTRL_MEM_READ_BIT  = 1;
  localparam int CTRL_MEM_WRITE_BIT = 2;
  localparam int CTRL_BRANCH_BIT    = 3;
  localparam int CTRL_JUMP_BIT      = 4;
  localparam int CTRL_ALU_SRC_BIT   = 5;
  localparam int CTRL_ALU_OP_LSB    = 6;
  localparam int CTRL_ALU_OP_W      = 4;
  localparam int CTRL_WB_SEL_LSB    = 10;
  localparam int CTRL_WB_SEL_W      = 2;

  // ALU operation encodings; ADD is the harmless choice for a bubble.
  localparam logic [CTRL_ALU_OP_W-1:0] ALU_OP_ADD = 4'd0;
  localparam logic [CTRL_ALU_OP_W-1:0] ALU_OP_SUB = 4'd1;
  localparam logic [CTRL_ALU_OP_W-1:0] ALU_OP_AND = 4'd2;
  localparam logic [CTRL_ALU_OP_W-1:0] ALU_OP_OR  = 4'd3;

  // Write-back source select; WB_NONE marks a slot that writes nothing back.
  localparam logic [CTRL_WB_SEL_W-1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [CTRL_WB_SEL_W-1:0] WB_SEL_MEM  = 2'd1;
  localparam logic [CTRL_WB_SEL_W-1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [CTRL_WB_SEL_W-1:0] WB_SEL_NONE = 2'd3;

  // ---------------------------------------------------------------------------
  // Per-boundary payload and control widths.
  // IF/ID carries PC and instruction; ID/EX carries PC, two operands,
  // immediate and register addresses; later stages carry progressively less.
  // ---------------------------------------------------------------------------
  localparam int IFID_DATA_W  = 64;
  localparam int IFID_CTRL_W  = 4;
  localparam int IDEX_DATA_W  = 160;
  localparam int IDEX_CTRL_W  = 16;
  localparam int EXMEM_DATA_W = 112;
  localparam int EXMEM_CTRL_W = 12;
  localparam int MEMWB_DATA_W = 72;
  localparam int MEMWB_CTRL_W = 12;

  // ---------------------------------------------------------------------------
  // Bubble control values. A bubble must never write the register file or
  // memory and never redirect fetch, so all enables are zero and the
  // write-back select is the explicit no-op encoding.
  // ---------------------------------------------------------------------------
  localparam logic [IFID_CTRL_W-1:0] IFID_CTRL_BUBBLE = '0;

  localparam logic [IDEX_CTRL_W-1:0] IDEX_CTRL_BUBBLE = {
    4'b0000,       // reserved
    WB_SEL_NONE,   // write-back select
    ALU_OP_ADD,    // ALU operation
    1'b0,          // ALU source
    1'b0,          // jump
    1'b0,          // branch
    1'b0,          // memory write
    1'b0,          // memory read
    1'b0           // register write
  };

  localparam logic [EXMEM_CTRL_W-1:0] EXMEM_CTRL_BUBBLE =
    IDEX_CTRL_BUBBLE[EXMEM_CTRL_W-1:0];

  localparam logic [MEMWB_CTRL_W-1:0] MEMWB_CTRL_BUBBLE =
    IDEX_CTRL_BUBBLE[MEMWB_CTRL_W-1:0];

  // Number of beats held in a given occupancy state.
  function automatic logic [1:0] stateCount(input pipe_state_t st);
    case (st)
      ST_ONE:  return 2'd1;
      ST_TWO:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// Generic pipeline-stage register with a valid/ready handshake and a
// two-entry skid buffer. The main entry drives the outputs directly; the skid
// entry catches the beat upstream sends in the cycle before it observes the
// registered in_ready drop. A synchronous flush empties the stage and shows
// the bubble control value.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous, active-high
//   flush      synchronous kill of all held beats
//   in_valid   upstream beat present
//   in_ready   stage can accept a beat (flop output)
//   in_data    upstream payload, DATA_W bits
//   in_ctrl    upstream control bundle, CTRL_W bits
//   out_valid  out_data/out_ctrl hold a live beat
//   out_ready  downstream accepts the beat
//   out_data   registered payload (0 when empty)
//   out_ctrl   registered control (CTRL_BUBBLE when empty)
//   count      number of held beats, 0..2
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 160,
  parameter int                CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        count
);

  pipe_state_t       state;
  pipe_state_t       nextState;

  logic [DATA_W-1:0] mainData;
  logic [CTRL_W-1:0] mainCtrl;
  logic [DATA_W-1:0] skidData;
  logic [CTRL_W-1:0] skidCtrl;

  logic [DATA_W-1:0] nextMainData;
  logic [CTRL_W-1:0] nextMainCtrl;
  logic [DATA_W-1:0] nextSkidData;
  logic [CTRL_W-1:0] nextSkidCtrl;

  logic              inReadyQ;
  logic              outValidQ;
  logic [1:0]        countQ;

  logic              accept;
  logic              deliver;

  // Handshakes seen at the coming edge. Both are qualified by flop outputs,
  // so nothing here feeds back into in_ready combinationally.
  always_comb begin
    accept  = in_valid & inReadyQ;
    deliver = outValidQ & out_ready;
  end

  // Next-state and entry update. Flush wins over every handshake: the stage
  // empties, and a beat accepted in the same cycle is simply never stored.
  // Whenever main becomes empty it is reloaded with the bubble so the
  // outputs never show a stale instruction.
  always_comb begin
    nextState    = state;
    nextMainData = mainData;
    nextMainCtrl = mainCtrl;
    nextSkidData = skidData;
    nextSkidCtrl = skidCtrl;

    if (flush) begin
      nextState    = ST_EMPTY;
      nextMainData = '0;
      nextMainCtrl = CTRL_BUBBLE;
      nextSkidData = '0;
      nextSkidCtrl = CTRL_BUBBLE;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            nextState    = ST_ONE;
            nextMainData = in_data;
            nextMainCtrl = in_ctrl;
          end
        end

        ST_ONE: begin
          if (accept && deliver) begin
            nextMainData = in_data;
            nextMainCtrl = in_ctrl;
          end else if (accept) begin
            nextState    = ST_TWO;
            nextSkidData = in_data;
            nextSkidCtrl = in_ctrl;
          end else if (deliver) begin
            nextState    = ST_EMPTY;
            nextMainData = '0;
            nextMainCtrl = CTRL_BUBBLE;
          end
        end

        ST_TWO: begin
          // in_ready is low here, so only a delivery can happen.
          if (deliver) begin
            nextState    = ST_ONE;
            nextMainData = skidData;
            nextMainCtrl = skidCtrl;
            nextSkidData = '0;
            nextSkidCtrl = CTRL_BUBBLE;
          end
        end

        default: begin
          nextState    = ST_EMPTY;
          nextMainData = '0;
          nextMainCtrl = CTRL_BUBBLE;
          nextSkidData = '0;
          nextSkidCtrl = CTRL_BUBBLE;
        end
      endcase
    end
  end

  // State register and both entries. The status flags are registered from
  // the next state so in_ready, out_valid and count are pure flop outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_EMPTY;
      mainData  <= '0;
      mainCtrl  <= CTRL_BUBBLE;
      skidData  <= '0;
      skidCtrl  <= CTRL_BUBBLE;
      inReadyQ  <= 1'b1;
      outValidQ <= 1'b0;
      countQ    <= 2'd0;
    end else begin
      state     <= nextState;
      mainData  <= nextMainData;
      mainCtrl  <= nextMainCtrl;
      skidData  <= nextSkidData;
      skidCtrl  <= nextSkidCtrl;
      inReadyQ  <= (nextState != ST_TWO);
      outValidQ <= (nextState != ST_EMPTY);
      countQ    <= stateCount(nextState);
    end
  end

  // Outputs come straight from the main entry and the status flops.
  always_comb begin
    in_ready  = inReadyQ;
    out_valid = outValidQ;
    out_data  = mainData;
    out_ctrl  = mainCtrl;
    count     = countQ;
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid
// Directed and randomised checks of pipe_stage_skid with a narrow payload and
// a non-zero bubble control value, so bubble insertion is observable.
module tb_pipe_stage_skid;

  localparam int              DW     = 32;
  localparam int              CW     = 16;
  localparam logic [CW-1:0]   BUBBLE = 16'h0C00;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          inValid;
  logic          inReady;
  logic [DW-1:0] inData;
  logic [CW-1:0] inCtrl;
  logic          outValid;
  logic          outReady;
  logic [DW-1:0] outData;
  logic [CW-1:0] outCtrl;
  logic [1:0]    count;

  int total;
  int bad;

  pipe_stage_skid #(
    .DATA_W      (DW),
    .CTRL_W      (CW),
    .CTRL_BUBBLE (BUBBLE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_data   (inData),
    .in_ctrl   (inCtrl),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_data  (outData),
    .out_ctrl  (outCtrl),
    .count     (count)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control value carried alongside each payload in this bench.
  function automatic logic [CW-1:0] ctrlOf(input logic [DW-1:0] d);
    return d[CW-1:0] ^ 16'h5A5A;
  endfunction

  // Drive all upstream/downstream inputs at once.
  task automatic applyStimulus(input logic iv, input logic [DW-1:0] d,
                               input logic ordy, input logic fl);
    inValid  = iv;
    inData   = d;
    inCtrl   = ctrlOf(d);
    outReady = ordy;
    flush    = fl;
  endtask

  // Advance one edge and settle 1 ns after it.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // One counted comparison.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Full-status check of the stage outputs.
  task automatic checkStage(input string tag, input logic v, input logic [DW-1:0] d,
                            input logic [CW-1:0] c, input logic [1:0] n,
                            input logic rdy);
    checkOutput({tag, ".out_valid"}, 64'(outValid), 64'(v));
    checkOutput({tag, ".out_data"},  64'(outData),  64'(d));
    checkOutput({tag, ".out_ctrl"},  64'(outCtrl),  64'(c));
    checkOutput({tag, ".count"},     64'(count),    64'(n));
    checkOutput({tag, ".in_ready"},  64'(inReady),  64'(rdy));
  endtask

  logic [DW-1:0] sb[$];
  logic [DW-1:0] seqNum;
  logic          rIv;
  logic          rOr;
  logic          rFl;
  logic          acc;
  logic          dlv;
  int            maxCount;

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // Reset values before any clock edge.
    #2;
    checkStage("reset", 1'b0, '0, BUBBLE, 2'd0, 1'b1);
    #10;
    reset = 1'b0;
    stepClock();
    checkStage("idle", 1'b0, '0, BUBBLE, 2'd0, 1'b1);

    // Streaming 1..4 with out_ready high: one beat per cycle, count stays 1.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, DW'(i), 1'b1, 1'b0);
      stepClock();
      checkStage($sformatf("stream%0d", i), 1'b1, DW'(i), ctrlOf(DW'(i)), 2'd1, 1'b1);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    stepClock();
    checkStage("drain", 1'b0, '0, BUBBLE, 2'd0, 1'b1);

    // Stall: A then B with out_ready low fills the skid.
    applyStimulus(1'b1, 32'h0000_00AA, 1'b0, 1'b0);
    stepClock();
    checkStage("stallA", 1'b1, 32'h0000_00AA, ctrlOf(32'h0000_00AA), 2'd1, 1'b1);
    applyStimulus(1'b1, 32'h0000_00BB, 1'b0, 1'b0);
    stepClock();
    checkStage("stallB", 1'b1, 32'h0000_00AA, ctrlOf(32'h0000_00AA), 2'd2, 1'b0);
    // Held while stalled even with a beat offered.
    applyStimulus(1'b1, 32'h0000_00EE, 1'b0, 1'b0);
    stepClock();
    checkStage("hold", 1'b1, 32'h0000_00AA, ctrlOf(32'h0000_00AA), 2'd2, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    stepClock();
    checkStage("relA", 1'b1, 32'h0000_00BB, ctrlOf(32'h0000_00BB), 2'd1, 1'b1);
    stepClock();
    checkStage("relB", 1'b0, '0, BUBBLE, 2'd0, 1'b1);

    // Flush while TWO.
    applyStimulus(1'b1, 32'h0000_0A0A, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b1, 32'h0000_0B0B, 1'b0, 1'b0);
    stepClock();
    checkOutput("preflush.count", 64'(count), 64'd2);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    stepClock();
    checkStage("flushTwo", 1'b0, '0, BUBBLE, 2'd0, 1'b1);

    // Flush in EMPTY with a simultaneous beat C: C is discarded.
    applyStimulus(1'b1, 32'h0000_0C0C, 1'b0, 1'b1);
    stepClock();
    checkStage("flushC", 1'b0, '0, BUBBLE, 2'd0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    stepClock();
    checkStage("afterC", 1'b0, '0, BUBBLE, 2'd0, 1'b1);

    // Async reset while ONE, between edges.
    applyStimulus(1'b1, 32'h0000_0D0D, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkStage("oneD", 1'b1, 32'h0000_0D0D, ctrlOf(32'h0000_0D0D), 2'd1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checkStage("asyncRst", 1'b0, '0, BUBBLE, 2'd0, 1'b1);
    #2;
    reset = 1'b0;
    stepClock();
    checkStage("postRst", 1'b0, '0, BUBBLE, 2'd0, 1'b1);

    // Randomised traffic against a queue model, with rare flushes.
    seqNum   = 32'h1000;
    maxCount = 0;
    sb.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      rIv = ($urandom_range(0, 99) < 60);
      rOr = ($urandom_range(0, 99) < 55);
      rFl = ($urandom_range(0, 199) == 0);
      applyStimulus(rIv, seqNum, rOr, rFl);
      #1;
      checkOutput("rnd.in_ready",  64'(inReady),  64'(sb.size() != 2));
      checkOutput("rnd.out_valid", 64'(outValid), 64'(sb.size() != 0));
      checkOutput("rnd.count",     64'(count),    64'(sb.size()));
      if (sb.size() != 0) begin
        checkOutput("rnd.out_data", 64'(outData), 64'(sb[0]));
        checkOutput("rnd.out_ctrl", 64'(outCtrl), 64'(ctrlOf(sb[0])));
      end else begin
        checkOutput("rnd.bubble", 64'(outCtrl), 64'(BUBBLE));
      end
      if (int'(count) > maxCount) maxCount = int'(count);
      acc = rIv && (sb.size() != 2);
      dlv = rOr && (sb.size() != 0);
      stepClock();
      if (rFl) begin
        sb.delete();
      end else begin
        if (dlv) void'(sb.pop_front());
        if (acc) sb.push_back(seqNum);
      end
      if (acc) seqNum = seqNum + 1;
    end
    checkOutput("rnd.maxCount", 64'(maxCount <= 2), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
